// File: rtl/sd_host_pkg.sv
// rtl/sd_host_pkg.sv - shared widths, encodings and scheduler state type
package sd_host_pkg;

   localparam int CMD_W  = 38;
   localparam int RESP_W = 127;

   localparam logic [1:0] RT_NONE = 2'b00;
   localparam logic [1:0] RT_R1   = 2'b01;
   localparam logic [1:0] RT_R2   = 2'b10;
   localparam logic [1:0] RT_R3   = 2'b11;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_CRC     = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_SEND,
      S_RECV,
      S_DONE
   } sched_state_t;

endpackage

// File: rtl/sd_cmd_scheduler_if.sv
// rtl/sd_cmd_scheduler_if.sv - requester-side request/response bundle
interface sd_cmd_scheduler_if;
   import sd_host_pkg::*;

   logic [1:0]        req_valid;
   logic [CMD_W-1:0]  req_cmd0;
   logic [CMD_W-1:0]  req_cmd1;
   logic [1:0]        req_rtype0;
   logic [1:0]        req_rtype1;
   logic [1:0]        req_ack;
   logic [1:0]        grant;
   logic [1:0]        done;
   logic [1:0]        status;
   logic [RESP_W-1:0] resp;
   logic              busy;

   modport master (
      output req_valid, req_cmd0, req_cmd1, req_rtype0, req_rtype1,
      input  req_ack, grant, done, status, resp, busy
   );

   modport slave (
      input  req_valid, req_cmd0, req_cmd1, req_rtype0, req_rtype1,
      output req_ack, grant, done, status, resp, busy
   );

endinterface

// File: rtl/sd_rr_arbiter2.sv
// rtl/sd_rr_arbiter2.sv - two-way round-robin winner select with priority pointer
module sd_rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_valid,
   input  logic       take,
   output logic [1:0] win
);

   logic rr;

   // Winner: the requester rr points at if it is valid, otherwise the other one
   always_comb begin
      win = 2'b00;
      if (rr) begin
         if (req_valid[1])      win = 2'b10;
         else if (req_valid[0]) win = 2'b01;
      end else begin
         if (req_valid[0])      win = 2'b01;
         else if (req_valid[1]) win = 2'b10;
      end
   end

   // Priority moves to the non-winner each time a grant is taken
   always_ff @(posedge clk) begin
      if (rst)       rr <= 1'b0;
      else if (take) rr <= win[0];
   end

endmodule

// File: rtl/sd_cmd_scheduler.sv
// rtl/sd_cmd_scheduler.sv - shares one CMD-line send/receive engine between two requesters
module sd_cmd_scheduler
   import sd_host_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic              ex_clk,
   input  logic              sd_reset,
   sd_cmd_scheduler_if.slave bus,
   output logic              send_en,
   output logic [CMD_W-1:0]  send_cmd_content,
   input  logic              sd_finished,
   output logic              receive_en,
   output logic              R2_response,
   output logic              R3_response,
   input  logic              sd_receive_finished,
   input  logic              crc_response_err,
   input  logic [RESP_W-1:0] response
);

   localparam int            TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO = TW'(TIMEOUT_CYCLES);

   sched_state_t      state, state_d;
   logic [1:0]        win;
   logic              take;
   logic [1:0]        rtype_q, rtype_d;
   logic [CMD_W-1:0]  cmd_d;
   logic [TW-1:0]     timer, timer_d, timer_inc;
   logic              timer_hit;
   logic [1:0]        grant_d, status_d;
   logic [RESP_W-1:0] resp_d;
   logic              done_fire;

   assign take = (state == S_IDLE) && (win != 2'b00);

   sd_rr_arbiter2 u_arb (
      .clk       (ex_clk),
      .rst       (sd_reset),
      .req_valid (bus.req_valid),
      .take      (take),
      .win       (win)
   );

   // The phase ends on the cycle in which the count reaches TIMEOUT_CYCLES
   assign timer_inc = (timer == TO) ? TO : timer + 1'b1;
   assign timer_hit = (timer_inc == TO);

   // Next state and next values of every registered output
   always_comb begin
      state_d   = state;
      timer_d   = timer;
      rtype_d   = rtype_q;
      cmd_d     = send_cmd_content;
      grant_d   = bus.grant;
      status_d  = bus.status;
      resp_d    = bus.resp;
      done_fire = 1'b0;
      case (state)
         S_IDLE: begin
            if (take) begin
               rtype_d = win[1] ? bus.req_rtype1 : bus.req_rtype0;
               cmd_d   = win[1] ? bus.req_cmd1 : bus.req_cmd0;
               grant_d = win;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            timer_d = '0;
            state_d = S_WAIT_SEND;
         end
         S_WAIT_SEND: begin
            timer_d = timer_inc;
            if (sd_finished) begin
               if (rtype_q == RT_NONE) begin
                  status_d  = ST_OK;
                  resp_d    = '0;
                  done_fire = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  timer_d = '0;
                  state_d = S_RECV;
               end
            end else if (timer_hit) begin
               status_d  = ST_TIMEOUT;
               resp_d    = '0;
               done_fire = 1'b1;
               state_d   = S_DONE;
            end
         end
         S_RECV: begin
            timer_d = timer_inc;
            if (sd_receive_finished) begin
               resp_d    = response;
               status_d  = crc_response_err ? ST_CRC : ST_OK;
               done_fire = 1'b1;
               state_d   = S_DONE;
            end else if (timer_hit) begin
               resp_d    = '0;
               status_d  = ST_TIMEOUT;
               done_fire = 1'b1;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            grant_d = 2'b00;
            state_d = S_IDLE;
         end
         default: begin
            grant_d = 2'b00;
            state_d = S_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge ex_clk) begin
      if (sd_reset) state <= S_IDLE;
      else          state <= state_d;
   end

   // Timer, latches and registered outputs
   always_ff @(posedge ex_clk) begin
      if (sd_reset) begin
         timer            <= '0;
         rtype_q          <= RT_NONE;
         send_cmd_content <= '0;
         bus.grant        <= 2'b00;
         bus.req_ack      <= 2'b00;
         bus.done         <= 2'b00;
         bus.status       <= ST_OK;
         bus.resp         <= '0;
         bus.busy         <= 1'b0;
         send_en          <= 1'b0;
         receive_en       <= 1'b0;
         R2_response      <= 1'b0;
         R3_response      <= 1'b0;
      end else begin
         timer            <= timer_d;
         rtype_q          <= rtype_d;
         send_cmd_content <= cmd_d;
         bus.grant        <= grant_d;
         bus.req_ack      <= take ? win : 2'b00;
         bus.done         <= done_fire ? bus.grant : 2'b00;
         bus.status       <= status_d;
         bus.resp         <= resp_d;
         bus.busy         <= (state_d != S_IDLE);
         send_en          <= (state_d == S_SEND);
         receive_en       <= (state_d == S_RECV);
         R2_response      <= (state_d == S_RECV) && (rtype_d == RT_R2);
         R3_response      <= (state_d == S_RECV) && (rtype_d == RT_R3);
      end
   end

endmodule

// File: tb/tb_sd_cmd_scheduler.sv
// tb/tb_sd_cmd_scheduler.sv - scoreboard bench for sd_cmd_scheduler
`timescale 1ns/1ps
module tb_sd_cmd_scheduler;
   import sd_host_pkg::*;

   localparam int TO_LONG  = 4096;
   localparam int TO_SHORT = 16;

   localparam logic [RESP_W-1:0] RSP_R1 = 127'h0800_0001_AAB3;
   localparam logic [RESP_W-1:0] RSP_R2 = 127'h0DEAD_BEEF_CAFE_F00D_1234_5678;
   localparam logic [RESP_W-1:0] RSP_R3 = 127'h3F_80FF_8000_FF;
   localparam logic [RESP_W-1:0] JUNK   = 127'h5A5A_A5A5_5A5A_A5A5;

   typedef struct {
      logic [1:0]        owner;
      logic [1:0]        status;
      logic [RESP_W-1:0] resp;
   } done_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              sd_reset, use_short;
   logic [1:0]        rv;
   logic [CMD_W-1:0]  c0, c1;
   logic [1:0]        t0, t1;
   logic              sd_finished, sd_receive_finished, crc_response_err;
   logic [RESP_W-1:0] response;

   int checks = 0;
   int errors = 0;
   done_t      exp_done_q[$];
   logic [1:0] exp_ack_q[$];

   sd_cmd_scheduler_if ifa();
   sd_cmd_scheduler_if ifb();

   assign ifa.req_valid  = use_short ? 2'b00 : rv;
   assign ifb.req_valid  = use_short ? rv : 2'b00;
   assign ifa.req_cmd0   = c0;
   assign ifa.req_cmd1   = c1;
   assign ifa.req_rtype0 = t0;
   assign ifa.req_rtype1 = t1;
   assign ifb.req_cmd0   = c0;
   assign ifb.req_cmd1   = c1;
   assign ifb.req_rtype0 = t0;
   assign ifb.req_rtype1 = t1;

   logic             send_en_a, send_en_b, recv_a, recv_b, r2_a, r2_b, r3_a, r3_b;
   logic [CMD_W-1:0] cmd_a, cmd_b;

   sd_cmd_scheduler #(.TIMEOUT_CYCLES(TO_LONG)) dut_a (
      .ex_clk(clk), .sd_reset(sd_reset), .bus(ifa),
      .send_en(send_en_a), .send_cmd_content(cmd_a), .sd_finished(sd_finished),
      .receive_en(recv_a), .R2_response(r2_a), .R3_response(r3_a),
      .sd_receive_finished(sd_receive_finished), .crc_response_err(crc_response_err),
      .response(response)
   );

   sd_cmd_scheduler #(.TIMEOUT_CYCLES(TO_SHORT)) dut_b (
      .ex_clk(clk), .sd_reset(sd_reset), .bus(ifb),
      .send_en(send_en_b), .send_cmd_content(cmd_b), .sd_finished(sd_finished),
      .receive_en(recv_b), .R2_response(r2_b), .R3_response(r3_b),
      .sd_receive_finished(sd_receive_finished), .crc_response_err(crc_response_err),
      .response(response)
   );

   wire [1:0]        ack_m        = use_short ? ifb.req_ack : ifa.req_ack;
   wire [1:0]        grant_m      = use_short ? ifb.grant   : ifa.grant;
   wire [1:0]        done_m       = use_short ? ifb.done    : ifa.done;
   wire [1:0]        status_m     = use_short ? ifb.status  : ifa.status;
   wire [RESP_W-1:0] resp_m       = use_short ? ifb.resp    : ifa.resp;
   wire              busy_m       = use_short ? ifb.busy    : ifa.busy;
   wire              send_en_m    = use_short ? send_en_b   : send_en_a;
   wire              receive_en_m = use_short ? recv_b      : recv_a;
   wire              r2_m         = use_short ? r2_b        : r2_a;
   wire              r3_m         = use_short ? r3_b        : r3_a;
   wire [CMD_W-1:0]  cmd_m        = use_short ? cmd_b       : cmd_a;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every ack/done pulse is matched against the scoreboard
   always @(negedge clk) begin : monitor
      done_t      ed;
      logic [1:0] ea;
      if (ack_m != 2'b00) begin
         if (exp_ack_q.size() == 0) chk("unexpected_ack", {126'd0, ack_m}, 128'd0);
         else begin
            ea = exp_ack_q.pop_front();
            chk("req_ack", {126'd0, ack_m}, {126'd0, ea});
         end
      end
      if (done_m != 2'b00) begin
         if (exp_done_q.size() == 0) chk("unexpected_done", {126'd0, done_m}, 128'd0);
         else begin
            ed = exp_done_q.pop_front();
            chk("done_owner", {126'd0, done_m}, {126'd0, ed.owner});
            chk("done_status", {126'd0, status_m}, {126'd0, ed.status});
            chk("done_resp", {1'b0, resp_m}, {1'b0, ed.resp});
         end
      end
   end

   // Plays sd_send/sd_receive from the cycle send_en is seen; n = RECV cycle of finish, 0 = never
   task automatic respond(input int sdly, input logic [1:0] rt, input int n,
                          input logic crc, input logic [RESP_W-1:0] rsp);
      int cnt;
      bit r_ok;
      for (int i = 0; i < sdly; i++) begin
         tick();
         if (i == 0) chk("send_en_pulse", send_en_m, 0);
      end
      sd_finished = 1'b1;
      tick();
      sd_finished = 1'b0;
      if (rt == RT_NONE) begin
         chk("no_receive_en", receive_en_m, 0);
         chk("done_after_send", done_m != 2'b00, 1);
      end else begin
         cnt  = 0;
         r_ok = 1'b1;
         while (receive_en_m && cnt < 5000) begin
            cnt++;
            if (r2_m != (rt == RT_R2) || r3_m != (rt == RT_R3)) r_ok = 1'b0;
            if (cnt == n) begin
               sd_receive_finished = 1'b1;
               crc_response_err    = crc;
               response            = rsp;
            end
            tick();
            sd_receive_finished = 1'b0;
            crc_response_err    = 1'b0;
            response            = JUNK;
         end
         chk("recv_cycles", cnt, (n > 0) ? n : (use_short ? TO_SHORT : TO_LONG));
         chk("rtype_flags", r_ok, 1);
         chk("done_after_recv", done_m != 2'b00, 1);
      end
      tick();
      chk("grant_clear", grant_m, 0);
      chk("busy_clear", busy_m, 0);
   endtask

   task automatic single(input int req, input logic [CMD_W-1:0] cmd, input logic [1:0] rt,
                         input int sdly, input int n, input logic crc,
                         input logic [RESP_W-1:0] rsp, input logic [1:0] est,
                         input logic [RESP_W-1:0] eresp);
      logic [1:0] m;
      done_t      e;
      m = (req == 0) ? 2'b01 : 2'b10;
      exp_ack_q.push_back(m);
      e.owner = m; e.status = est; e.resp = eresp;
      exp_done_q.push_back(e);
      if (req == 0) begin c0 = cmd; t0 = rt; end
      else          begin c1 = cmd; t1 = rt; end
      rv = m;
      tick();
      chk("ack_T1", ack_m, m);
      chk("send_en_T1", send_en_m, 1);
      chk("grant_T1", grant_m, m);
      chk("busy_T1", busy_m, 1);
      chk("cmd_T1", cmd_m, cmd);
      rv = 2'b00;
      c0 = '1;
      c1 = '1;
      respond(sdly, rt, n, crc, rsp);
      chk("cmd_stable", cmd_m, cmd);
   endtask

   task automatic wait_send(output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!send_en_m && cyc < 100);
   endtask

   task automatic do_reset();
      sd_reset = 1'b1;
      tick();
      tick();
      sd_reset = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int         cyc;
      logic [1:0] order [3];
      done_t      e;
      order = '{2'b01, 2'b10, 2'b01};
      use_short = 1'b0; rv = 2'b00; c0 = '0; c1 = '0; t0 = RT_NONE; t1 = RT_NONE;
      sd_finished = 1'b0; sd_receive_finished = 1'b0; crc_response_err = 1'b0;
      response = JUNK;
      do_reset();
      tick();
      chk("rst_grant", grant_m, 0);
      chk("rst_busy", busy_m, 0);
      chk("rst_send_en", send_en_m, 0);
      chk("rst_cmd", cmd_m, 0);
      chk("rst_status_resp", {status_m, resp_m}, 0);
      chk("rst_recv_flags", {receive_en_m, r2_m, r3_m, ack_m, done_m}, 0);

      // CMD8 R1, send 50 cycles, response 30 cycles later
      single(0, {6'd8, 32'h1AA}, RT_R1, 50, 30, 1'b0, RSP_R1, ST_OK, RSP_R1);
      // CMD0, no response
      single(1, {6'd0, 32'h0}, RT_NONE, 5, 0, 1'b0, JUNK, ST_OK, '0);
      // CMD2 R2 with CRC error
      single(0, {6'd2, 32'h0}, RT_R2, 10, 20, 1'b1, RSP_R2, ST_CRC, RSP_R2);
      // ACMD41 R3
      single(1, {6'd41, 32'h40FF_8000}, RT_R3, 4, 5, 1'b0, RSP_R3, ST_OK, RSP_R3);

      // Contention from reset: both held valid, grants alternate 0,1,0
      do_reset();
      c0 = {6'd13, 32'h1111}; c1 = {6'd55, 32'h2222}; t0 = RT_NONE; t1 = RT_NONE;
      for (int k = 0; k < 3; k++) begin
         exp_ack_q.push_back(order[k]);
         e.owner = order[k]; e.status = ST_OK; e.resp = '0;
         exp_done_q.push_back(e);
      end
      rv = 2'b11;
      for (int k = 0; k < 3; k++) begin
         wait_send(cyc);
         chk(k == 0 ? "contend_latency" : "b2b_spacing", cyc, 1);
         chk("contend_grant", grant_m, order[k]);
         chk("contend_cmd", cmd_m, (k == 1) ? c1 : c0);
         if (k == 2) rv = 2'b00;
         respond(3, RT_NONE, 0, 1'b0, '0);
      end

      // Short-timeout instance
      use_short = 1'b1;
      do_reset();
      single(0, {6'd8, 32'h1AA}, RT_R1, 3, 0, 1'b0, JUNK, ST_TIMEOUT, '0);
      single(1, {6'd8, 32'h1AA}, RT_R1, 3, 16, 1'b0, RSP_R1, ST_OK, RSP_R1);
      single(0, {6'd17, 32'h10}, RT_R1, 2, 4, 1'b1, RSP_R2, ST_CRC, RSP_R2);

      // Reset in RECV: abandoned, no done, rr returns to 0
      exp_ack_q.push_back(2'b01);
      c0 = {6'd17, 32'h20}; t0 = RT_R1;
      rv = 2'b01;
      tick();
      rv = 2'b00;
      repeat (2) tick();
      sd_finished = 1'b1;
      tick();
      sd_finished = 1'b0;
      chk("mid_in_recv", receive_en_m, 1);
      repeat (3) tick();
      sd_reset = 1'b1;
      tick();
      sd_reset = 1'b0;
      chk("mid_rst_ctrl", {grant_m, busy_m, receive_en_m, send_en_m, done_m}, 0);
      chk("mid_rst_data", {status_m, resp_m}, 0);
      chk("mid_rst_cmd", cmd_m, 0);
      tick();
      chk("mid_no_done", done_m, 0);
      t0 = RT_NONE; t1 = RT_NONE;
      exp_ack_q.push_back(2'b01);
      e.owner = 2'b01; e.status = ST_OK; e.resp = '0;
      exp_done_q.push_back(e);
      rv = 2'b11;
      tick();
      chk("rr_after_reset", grant_m, 2'b01);
      rv = 2'b00;
      respond(2, RT_NONE, 0, 1'b0, '0);

      repeat (3) tick();
      chk("queues_drained", exp_ack_q.size() + exp_done_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
